reg_bank: RTL and testbench
===========================

// Module: reg_bank
// PURPOSE
//  General-purpose register file of the MIPS pipeline; consumer of the writeback stage output.
//  Accepts one write per cycle from WB (data, dest addr, enable) and serves two combinational read ports to ID.
//  Same-cycle write->read bypass removes the WB/ID structural hazard.
//  Debug dump sequencer streams all registers to the debug unit over a valid/ready handshake.
// PARAMETERS
//  NB_DATA     32  register width in bits
//  NB_REG_ADDR 5   register address width; depth = 2**NB_REG_ADDR (32)
// PORTS
//  clk_i          in   1            clock, all state updates on rising edge
//  rst_n_i        in   1            asynchronous reset, active-low
//  wr_en_i        in   1            WB write enable (RegWrite from WB stage)
//  wr_addr_i      in   NB_REG_ADDR  WB destination register
//  wr_data_i      in   NB_DATA      WB data (writeback mux output)
//  rs_addr_i      in   NB_REG_ADDR  ID read port A address
//  rt_addr_i      in   NB_REG_ADDR  ID read port B address
//  rs_data_o      out  NB_DATA      read port A data (combinational)
//  rt_data_o      out  NB_DATA      read port B data (combinational)
//  dump_start_i   in   1            debug: start full-register dump (level sampled in IDLE)
//  dump_ready_i   in   1            debug: sink accepts current word
//  dump_valid_o   out  1            debug: dump_data_o/dump_idx_o valid
//  dump_idx_o     out  NB_REG_ADDR  debug: index of word being offered
//  dump_data_o    out  NB_DATA      debug: register contents at dump_idx_o
//  dump_done_o    out  1            debug: one-cycle pulse after last word accepted
// BEHAVIOUR
//  Reset (rst_n_i=0, async): all registers 0; FSM=IDLE; dump_valid_o=0, dump_done_o=0, dump_idx_o=0.
//   rs/rt_data_o are combinational and read 0 during/after reset. Deassertion takes effect on next clock edge.
//  Write: rising edge with wr_en_i=1 and wr_addr_i!=0 -> regs[wr_addr_i]<=wr_data_i. Writes to r0 dropped.
//  Read: rs_data_o = (rs_addr_i==0) ? 0 : (wr_en_i && wr_addr_i==rs_addr_i) ? wr_data_i : regs[rs_addr_i].
//   Same rule for rt. Zero latency, bypass is combinational from the write port.
//   r0 always reads 0, even when wr_en_i=1 and wr_addr_i=0 with nonzero data.
//  Dump FSM, states IDLE, SEND, DONE:
//   IDLE: dump_valid_o=0. dump_start_i=1 -> SEND, idx<=0.
//   SEND: dump_valid_o=1, dump_idx_o=idx, dump_data_o=regs[idx] (stored value, no bypass; r0 gives 0).
//     Handshake: transfer when valid&&ready at a rising edge. Without ready, idx and data hold (data can
//     change only if WB writes regs[idx] that cycle). Transfer with idx<31 -> idx+1, stay SEND.
//     Transfer with idx==31 -> DONE. idx does not wrap.
//   DONE: dump_valid_o=0, dump_done_o=1 for exactly one cycle -> IDLE.
//   dump_start_i is ignored outside IDLE. If start is held high, a new dump begins the cycle after DONE.
//   WB writes stay enabled during a dump. A register written before its index is transferred is
//   dumped with its new value.
//   Async reset mid-dump aborts immediately: IDLE, valid=0, no done pulse.
//  Total dump with ready tied high: 32 SEND cycles + 1 DONE cycle; start-to-done = 33 cycles.
// TESTING
//  1 reset, then read rs=5, rt=31 -> both 0; write r0=0xDEADBEEF -> rs_addr=0 still reads 0.
//  2 write r7=0x12345678 with rs_addr=7 same cycle -> rs_data_o=0x12345678 before edge (bypass);
//    next cycle wr_en=0 -> still 0x12345678.
//  3 write r3=0xA, r4=0xB on consecutive cycles, read rs=3, rt=4 -> 0xA, 0xB; rst_n_i low mid-cycle -> both 0 at once.
//  4 regs[i]=i*0x11 preloaded, dump with ready=1 -> 32 words idx 0..31, data i*0x11 (idx0=0);
//    done pulses 1 cycle after idx31 transfer.
//  5 dump with ready toggling 1,0,0,1...; at idx=9 stall write r9=0x55 -> word 9 sent as 0x55,
//    no index skipped or repeated; start pulses during SEND are ignored.
//  6 assert rst_n_i at idx=15 of a dump -> valid drops, no done pulse; new start -> restarts at idx 0.

Source files
------------

// File: rtl/reg_bank_if.sv
// Bus bundle for reg_bank: WB write port, two ID read ports, and the debug dump stream.
interface reg_bank_if #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5
);
  logic                   wr_en_i;
  logic [NB_REG_ADDR-1:0] wr_addr_i;
  logic [NB_DATA-1:0]     wr_data_i;
  logic [NB_REG_ADDR-1:0] rs_addr_i;
  logic [NB_REG_ADDR-1:0] rt_addr_i;
  logic [NB_DATA-1:0]     rs_data_o;
  logic [NB_DATA-1:0]     rt_data_o;
  logic                   dump_start_i;
  logic                   dump_ready_i;
  logic                   dump_valid_o;
  logic [NB_REG_ADDR-1:0] dump_idx_o;
  logic [NB_DATA-1:0]     dump_data_o;
  logic                   dump_done_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, rt_addr_i,
    output dump_start_i, dump_ready_i,
    input  rs_data_o, rt_data_o, dump_valid_o, dump_idx_o, dump_data_o, dump_done_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, rs_addr_i, rt_addr_i,
    input  dump_start_i, dump_ready_i,
    output rs_data_o, rt_data_o, dump_valid_o, dump_idx_o, dump_data_o, dump_done_o
  );
endinterface

// File: rtl/reg_bank.sv
// MIPS general-purpose register file: one WB write port, two bypassed combinational read
// ports, and a valid/ready debug sequencer that streams every register in index order.
module reg_bank #(
  parameter int NB_DATA     = 32,
  parameter int NB_REG_ADDR = 5
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  reg_bank_if.slave  bus
);
  localparam int NREGS = 2 ** NB_REG_ADDR;
  localparam logic [NB_REG_ADDR-1:0] ADDR_ZERO = {NB_REG_ADDR{1'b0}};
  localparam logic [NB_REG_ADDR-1:0] ADDR_LAST = {NB_REG_ADDR{1'b1}};
  localparam logic [NB_REG_ADDR-1:0] ADDR_ONE  = NB_REG_ADDR'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  logic [NB_DATA-1:0]     regs_q [NREGS];
  state_t                 state_q, state_d;
  logic [NB_REG_ADDR-1:0] idx_q, idx_d;

  // Register storage; r0 is never written so it stays zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {NB_DATA{1'b0}};
      end
    end else if (bus.wr_en_i && (bus.wr_addr_i != ADDR_ZERO)) begin
      regs_q[bus.wr_addr_i] <= bus.wr_data_i;
    end else begin
      regs_q[bus.wr_addr_i] <= regs_q[bus.wr_addr_i];
    end
  end

  // Read port A with same-cycle WB bypass.
  always_comb begin
    bus.rs_data_o = {NB_DATA{1'b0}};
    if (bus.rs_addr_i == ADDR_ZERO) begin
      bus.rs_data_o = {NB_DATA{1'b0}};
    end else if (bus.wr_en_i && (bus.wr_addr_i == bus.rs_addr_i)) begin
      bus.rs_data_o = bus.wr_data_i;
    end else begin
      bus.rs_data_o = regs_q[bus.rs_addr_i];
    end
  end

  // Read port B with same-cycle WB bypass.
  always_comb begin
    bus.rt_data_o = {NB_DATA{1'b0}};
    if (bus.rt_addr_i == ADDR_ZERO) begin
      bus.rt_data_o = {NB_DATA{1'b0}};
    end else if (bus.wr_en_i && (bus.wr_addr_i == bus.rt_addr_i)) begin
      bus.rt_data_o = bus.wr_data_i;
    end else begin
      bus.rt_data_o = regs_q[bus.rt_addr_i];
    end
  end

  // Dump sequencer state and index registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= ADDR_ZERO;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Dump sequencer next-state; the index never wraps, the last transfer goes to DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.dump_start_i) begin
          state_d = ST_SEND;
          idx_d   = ADDR_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (bus.dump_ready_i) begin
          if (idx_q == ADDR_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + ADDR_ONE;
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = ADDR_ZERO;
      end
    endcase
  end

  // Dump outputs decode directly from registered state; data is the stored value, no bypass.
  always_comb begin
    bus.dump_valid_o = (state_q == ST_SEND);
    bus.dump_done_o  = (state_q == ST_DONE);
    bus.dump_idx_o   = idx_q;
    bus.dump_data_o  = regs_q[idx_q];
  end
endmodule

// File: tb/tb_reg_bank.sv
// Directed self-checking bench for reg_bank: reset, bypass reads, r0 rules and dump streaming.
module tb_reg_bank;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] mdl [32];
  int   exp_idx;
  int   cyc;
  logic wrote9;

  reg_bank_if bus ();

  reg_bank dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n            = 1'b0;
    bus.wr_en_i      = 1'b0;
    bus.wr_addr_i    = 5'd0;
    bus.wr_data_i    = 32'h0;
    bus.rs_addr_i    = 5'd5;
    bus.rt_addr_i    = 5'd31;
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b0;
    #12;
    chk("rst_valid", {31'h0, bus.dump_valid_o}, 32'h0);
    chk("rst_done",  {31'h0, bus.dump_done_o}, 32'h0);
    chk("rst_idx",   {27'h0, bus.dump_idx_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: reads after reset, r0 write dropped
    chk("t1_rs5",  bus.rs_data_o, 32'h0);
    chk("t1_rt31", bus.rt_data_o, 32'h0);
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 5'd0; bus.wr_data_i = 32'hDEADBEEF;
    bus.rs_addr_i = 5'd0;
    #1;
    chk("t1_r0_bypass", bus.rs_data_o, 32'h0);
    tick();
    bus.wr_en_i = 1'b0;
    #1;
    chk("t1_r0_after", bus.rs_data_o, 32'h0);

    // 2: same-cycle bypass then stored value
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 5'd7; bus.wr_data_i = 32'h12345678;
    bus.rs_addr_i = 5'd7; bus.rt_addr_i = 5'd7;
    #1;
    chk("t2_rs_bypass", bus.rs_data_o, 32'h12345678);
    chk("t2_rt_bypass", bus.rt_data_o, 32'h12345678);
    tick();
    bus.wr_en_i = 1'b0; bus.wr_data_i = 32'hFFFFFFFF;
    #1;
    chk("t2_rs_stored", bus.rs_data_o, 32'h12345678);

    // 3: consecutive writes, then async reset clears reads at once
    bus.wr_en_i = 1'b1; bus.wr_addr_i = 5'd3; bus.wr_data_i = 32'hA;
    tick();
    bus.wr_addr_i = 5'd4; bus.wr_data_i = 32'hB;
    tick();
    bus.wr_en_i = 1'b0; bus.wr_addr_i = 5'd0;
    bus.rs_addr_i = 5'd3; bus.rt_addr_i = 5'd4;
    #1;
    chk("t3_rs3", bus.rs_data_o, 32'hA);
    chk("t3_rt4", bus.rt_data_o, 32'hB);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t3_rs_rst", bus.rs_data_o, 32'h0);
    chk("t3_rt_rst", bus.rt_data_o, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // 4: preload regs[i]=i*0x11, dump with ready high
    bus.wr_en_i = 1'b1;
    for (int i = 1; i < 32; i++) begin
      bus.wr_addr_i = 5'(i);
      bus.wr_data_i = 32'(i * 32'h11);
      mdl[i] = 32'(i * 32'h11);
      tick();
    end
    bus.wr_en_i = 1'b0; bus.wr_addr_i = 5'd0;
    bus.dump_ready_i = 1'b1;
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("t4_valid", {31'h0, bus.dump_valid_o}, 32'h1);
      chk("t4_idx",   {27'h0, bus.dump_idx_o}, 32'(i));
      chk("t4_data",  bus.dump_data_o, mdl[i]);
      chk("t4_nodone", {31'h0, bus.dump_done_o}, 32'h0);
      tick();
    end
    @(negedge clk);
    chk("t4_done",      {31'h0, bus.dump_done_o}, 32'h1);
    chk("t4_done_valid", {31'h0, bus.dump_valid_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("t4_done_once", {31'h0, bus.dump_done_o}, 32'h0);
    chk("t4_idle_valid", {31'h0, bus.dump_valid_o}, 32'h0);
    tick();

    // 5: ready pattern 1,0,0 repeating, stalled write to r9, start pulses ignored
    exp_idx = 0; cyc = 0; wrote9 = 1'b0;
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    while (exp_idx < 32 && cyc < 300) begin
      bus.dump_ready_i = (cyc % 3 == 0);
      bus.dump_start_i = (cyc % 4 == 1);
      bus.wr_en_i = 1'b0;
      if (exp_idx == 9 && !wrote9 && !bus.dump_ready_i) begin
        bus.wr_en_i = 1'b1; bus.wr_addr_i = 5'd9; bus.wr_data_i = 32'h55;
      end
      @(negedge clk);
      chk("t5_valid", {31'h0, bus.dump_valid_o}, 32'h1);
      chk("t5_idx",   {27'h0, bus.dump_idx_o}, 32'(exp_idx));
      if (bus.dump_ready_i) begin
        chk("t5_data", bus.dump_data_o, mdl[exp_idx]);
        exp_idx++;
      end
      tick();
      if (bus.wr_en_i) begin
        mdl[9] = 32'h55;
        wrote9 = 1'b1;
        bus.wr_en_i = 1'b0;
      end
      cyc++;
    end
    bus.dump_start_i = 1'b0;
    bus.dump_ready_i = 1'b1;
    chk("t5_all_words", 32'(exp_idx), 32'd32);
    chk("t5_r9_written", {31'h0, wrote9}, 32'h1);
    @(negedge clk);
    chk("t5_done", {31'h0, bus.dump_done_o}, 32'h1);
    tick();
    tick();

    // 6: async reset mid-dump aborts, then restart from idx 0
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    @(negedge clk);
    chk("t6_idx15", {27'h0, bus.dump_idx_o}, 32'd15);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_valid_drop", {31'h0, bus.dump_valid_o}, 32'h0);
    chk("t6_idx_rst",    {27'h0, bus.dump_idx_o}, 32'h0);
    tick();
    @(negedge clk);
    chk("t6_no_done", {31'h0, bus.dump_done_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("t6_idle", {31'h0, bus.dump_valid_o}, 32'h0);
    tick();
    bus.dump_start_i = 1'b1;
    tick();
    bus.dump_start_i = 1'b0;
    @(negedge clk);
    chk("t6_restart_valid", {31'h0, bus.dump_valid_o}, 32'h1);
    chk("t6_restart_idx",   {27'h0, bus.dump_idx_o}, 32'h0);
    chk("t6_restart_data",  bus.dump_data_o, 32'h0);
    tick();
    @(negedge clk);
    chk("t6_next_idx",  {27'h0, bus.dump_idx_o}, 32'h1);
    chk("t6_next_data", bus.dump_data_o, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
